// File: rtl/cache_write_buffer_pkg.sv
// Shared widths and drain FSM encoding for the cache write buffer.
// Imported by the buffer top; sizes default the top's parameters.
package cache_write_buffer_pkg;

  localparam int MEM_ADDR_SIZE = 32;
  localparam int WORD_SIZE_BIT = 32;
  localparam int WBUF_DEPTH    = 4;

  typedef enum logic {
    WB_IDLE  = 1'b0,
    WB_WRITE = 1'b1
  } wb_state_t;

endpackage

// File: rtl/cache_write_buffer_cam_match.sv
// Word-address CAM over the buffer slots; reports youngest match.
// Ports: valid/addrs per slot, probe address, tail -> hit, index.
module wbuf_cam_match #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic [DEPTH-1:0]             valid,
  input  logic [DEPTH-1:0][ADDR_W-1:0] addrs,
  input  logic [ADDR_W-1:0]            probe,
  input  logic [$clog2(DEPTH)-1:0]     tail,
  output logic                         hit,
  output logic [$clog2(DEPTH)-1:0]     index
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] idx;

  // Walk oldest (tail) to youngest (tail-1); the last match wins.
  always_comb begin
    hit   = 1'b0;
    index = '0;
    idx   = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      idx = tail - PW'(k);
      if (valid[idx] &&
          addrs[idx][ADDR_W-1:2] == probe[ADDR_W-1:2]) begin
        hit   = 1'b1;
        index = idx;
      end
    end
  end

endmodule

// File: rtl/cache_write_buffer.sv
// FIFO write buffer between D-cache and memory, with read forwarding.
// Ports: clock/reset; push_*/full from cache; lookup_* probe and
// buffer_hit/lookup_data; mem_write/mem_addr/mem_data/mem_ack drain
// handshake; empty/count status. Macro WBUF_COALESCE_EN enables
// in-place merging of pushes that hit a buffered word.
module cache_write_buffer
  import cache_write_buffer_pkg::*;
#(
  parameter int DEPTH  = WBUF_DEPTH,
  parameter int ADDR_W = MEM_ADDR_SIZE,
  parameter int DATA_W = WORD_SIZE_BIT
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push_en,
  input  logic [ADDR_W-1:0]        push_addr,
  input  logic [DATA_W-1:0]        push_data,
  output logic                     full,
  input  logic                     lookup_en,
  input  logic [ADDR_W-1:0]        lookup_addr,
  output logic                     buffer_hit,
  output logic [DATA_W-1:0]        lookup_data,
  output logic                     mem_write,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_data,
  input  logic                     mem_ack,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0]             valid_q;
  logic [DEPTH-1:0][ADDR_W-1:0] addr_q;
  logic [DEPTH-1:0][DATA_W-1:0] data_q;
  logic [PW-1:0]                head_q;
  logic [PW-1:0]                tail_q;
  logic [CW-1:0]                count_q;
  wb_state_t                    state_q;
  wb_state_t                    state_d;

  logic          pop;
  logic          push_ok;
  logic          coal;
  logic [PW-1:0] co_idx;
  logic          lk_hit;
  logic [PW-1:0] lk_idx;

  assign count     = count_q;
  assign full      = count_q == CW'(DEPTH);
  assign empty     = count_q == '0;
  assign mem_write = state_q == WB_WRITE;
  assign pop       = mem_write && mem_ack;
  assign mem_addr  = mem_write ? addr_q[head_q] : '0;
  assign mem_data  = mem_write ? data_q[head_q] : '0;

  wbuf_cam_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_lookup (
    .valid (valid_q),
    .addrs (addr_q),
    .probe (lookup_addr),
    .tail  (tail_q),
    .hit   (lk_hit),
    .index (lk_idx)
  );

  assign buffer_hit  = lookup_en && lk_hit;
  assign lookup_data = buffer_hit ? data_q[lk_idx] : '0;

`ifdef WBUF_COALESCE_EN
  logic [DEPTH-1:0] co_valid;
  logic             co_hit;

  // The head is already on the bus while draining; never merge into it.
  always_comb begin
    co_valid = valid_q;
    if (mem_write) co_valid[head_q] = 1'b0;
  end

  wbuf_cam_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_coal (
    .valid (co_valid),
    .addrs (addr_q),
    .probe (push_addr),
    .tail  (tail_q),
    .hit   (co_hit),
    .index (co_idx)
  );

  assign coal    = push_en && co_hit;
  assign push_ok = push_en && !co_hit && !full;
`else
  assign coal    = 1'b0;
  assign co_idx  = '0;
  assign push_ok = push_en && !full;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WB_IDLE:  if (!empty) state_d = WB_WRITE;
      WB_WRITE: if (mem_ack)
                  state_d = (count_q > CW'(1)) ? WB_WRITE : WB_IDLE;
      default:  state_d = WB_IDLE;
    endcase
  end

  // Push and pop never touch the same slot: pop implies count>=1,
  // and a push is refused when the ring is full (tail==head).
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= WB_IDLE;
    end else begin
      state_q <= state_d;
      if (push_ok) begin
        addr_q[tail_q]  <= push_addr;
        data_q[tail_q]  <= push_data;
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + 1'b1;
      end
      if (coal) data_q[co_idx] <= push_data;
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      count_q <= count_q + CW'(push_ok) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_cache_write_buffer.sv
// Random + directed bench for cache_write_buffer against a queue model.
// Honours WBUF_COALESCE_EN in the model when the macro is defined.
module tb_cache_write_buffer;
  import cache_write_buffer_pkg::*;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        push_en = 1'b0;
  logic [31:0] push_addr = '0;
  logic [31:0] push_data = '0;
  logic        full;
  logic        lookup_en = 1'b0;
  logic [31:0] lookup_addr = '0;
  logic        buffer_hit;
  logic [31:0] lookup_data;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_ack = 1'b0;
  logic        empty;
  logic [2:0]  count;

  always #5 clock = ~clock;

  cache_write_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .push_en     (push_en),
    .push_addr   (push_addr),
    .push_data   (push_data),
    .full        (full),
    .lookup_en   (lookup_en),
    .lookup_addr (lookup_addr),
    .buffer_hit  (buffer_hit),
    .lookup_data (lookup_data),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .mem_ack     (mem_ack),
    .empty       (empty),
    .count       (count)
  );

  int   checks = 0;
  int   errors = 0;
  ent_t q[$];
  bit   busy = 1'b0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // One cycle: drive at negedge, check against model, advance model.
  task automatic step(input logic pe, input logic [31:0] pa,
                      input logic [31:0] pd, input logic ak,
                      input logic le, input logic [31:0] la);
    int   hi;
    int   ci;
    int   n;
    bit   pop;
    bit   acc;
    bit   nb;
    ent_t e;
    @(negedge clock);
    push_en = pe; push_addr = pa; push_data = pd;
    mem_ack = ak; lookup_en = le; lookup_addr = la;
    #1;
    n = q.size();
    chk("count", 64'(count), 64'(n));
    chk("full", 64'(full), 64'(n == DEPTH));
    chk("empty", 64'(empty), 64'(n == 0));
    chk("mem_write", 64'(mem_write), 64'(busy));
    chk("mem_addr", 64'(mem_addr), busy ? 64'(q[0].a) : 64'(0));
    chk("mem_data", 64'(mem_data), busy ? 64'(q[0].d) : 64'(0));
    hi = -1;
    if (le)
      for (int i = n - 1; i >= 0; i--)
        if (q[i].a[31:2] == la[31:2]) begin hi = i; break; end
    chk("buffer_hit", 64'(buffer_hit), 64'(hi >= 0));
    chk("lookup_data", 64'(lookup_data),
        hi >= 0 ? 64'(q[hi].d) : 64'(0));
    ci = -1;
`ifdef WBUF_COALESCE_EN
    if (pe)
      for (int i = n - 1; i >= (busy ? 1 : 0); i--)
        if (q[i].a[31:2] == pa[31:2]) begin ci = i; break; end
`endif
    pop = busy && ak;
    acc = pe && ci < 0 && n < DEPTH;
    if (busy) nb = ak ? (n > 1) : 1'b1;
    else      nb = n > 0;
    if (ci >= 0) begin
      e = q[ci]; e.d = pd; q[ci] = e;
    end
    if (pop) void'(q.pop_front());
    if (acc) begin
      e.a = pa; e.d = pd; q.push_back(e);
    end
    busy = nb;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; push_en = 1'b0; mem_ack = 1'b0;
    lookup_en = 1'b1; lookup_addr = 32'h0;
    @(negedge clock);
    #1;
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_empty", 64'(empty), 64'(1));
    chk("rst_full", 64'(full), 64'(0));
    chk("rst_mem_write", 64'(mem_write), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    chk("rst_mem_data", 64'(mem_data), 64'(0));
    chk("rst_hit", 64'(buffer_hit), 64'(0));
    chk("rst_lk_data", 64'(lookup_data), 64'(0));
    reset = 1'b0; lookup_en = 1'b0;
    q.delete();
    busy = 1'b0;
  endtask

  task automatic idle(input logic ak);
    step(1'b0, 32'h0, 32'h0, ak, 1'b0, 32'h0);
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    step(1'b1, a, d, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 20) begin idle(1'b1); n++; end
    @(negedge clock);
    #1;
    chk("drain_empty", 64'(empty), 64'(1));
  endtask

  initial begin
    do_reset();

    push(32'h100, 32'hAAAA0001);
    push(32'h104, 32'hAAAA0002);
    idle(1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);
    drain();

    for (int i = 0; i < 4; i++) push(32'h300 + 32'(i * 4), 32'(i));
    push(32'h200, 32'hBEEF);
    idle(1'b0);
    idle(1'b1);
    push(32'h200, 32'hBEEF);
    idle(1'b0);
    drain();

    push(32'h40, 32'h11);
    push(32'h40, 32'h22);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h40);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h44);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h43);
    drain();

    push(32'h500, 32'h1);
    push(32'h504, 32'h2);
    idle(1'b0);
    step(1'b1, 32'h508, 32'h3, 1'b1, 1'b0, 32'h0);
    idle(1'b0);
    push(32'h50C, 32'h4);
    push(32'h510, 32'h5);
    step(1'b1, 32'h514, 32'h6, 1'b1, 1'b0, 32'h0);
    idle(1'b0);
    drain();

    push(32'h600, 32'h1);
    push(32'h604, 32'h2);
    push(32'h608, 32'h3);
    idle(1'b0);
    do_reset();
    push(32'h700, 32'h7);
    idle(1'b0);
    drain();

`ifdef WBUF_COALESCE_EN
    for (int i = 0; i < 4; i++) push(32'h40 + 32'(i * 4), 32'(i));
    idle(1'b0);
    push(32'h48, 32'h33);
    push(32'h40, 32'h55);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h48);
    drain();
`endif

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(99) == 0) do_reset();
      else step(1'($urandom_range(1)),
                32'h100 + 32'($urandom_range(7) << 2)
                        + 32'($urandom_range(3)),
                $urandom,
                1'($urandom_range(1)),
                1'($urandom_range(1)),
                32'h100 + 32'($urandom_range(8) << 2)
                        + 32'($urandom_range(3)));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_write_buffer.md
Name: cache_write_buffer

Overview:
- FIFO write buffer between the data cache and main memory.
- Accepts word writes from the cache: dirty-block evictions and write-miss no-allocate stores.
- Drains them to memory through a valid/ack handshake.
- Answers read lookups so the cache can forward data that has not yet reached memory.

Parameters:
DEPTH, 4, number of buffered entries (power of two, >=2)
ADDR_W, `MEM_ADDR_SIZE, byte address width
DATA_W, `WORD_SIZE_BIT, word width

Ports:
clock  in  1  system clock, all state on posedge
reset  in  1  synchronous, active-high; clears all state
push_en  in  1  cache write request (cache's write_buffer strobe)
push_addr  in  ADDR_W  word address of write
push_data  in  DATA_W  write data
full  out  1  no free entry; push_en ignored while high
lookup_en  in  1  cache read probe (cache's read_buffer strobe)
lookup_addr  in  ADDR_W  probe address
buffer_hit  out  1  probe matches a valid entry
lookup_data  out  DATA_W  data of youngest matching entry
mem_write  out  1  head entry presented to memory
mem_addr  out  ADDR_W  head address
mem_data  out  DATA_W  head data
mem_ack  in  1  memory accepted head this cycle
empty  out  1  no valid entries
count  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Reset values: full=0, empty=1, count=0, mem_write=0, buffer_hit=0, mem_addr/mem_data/lookup_data=0. Pointers=0, all valid bits=0, FSM=IDLE.
- Reset mid-drain: all entries are dropped and mem_write is low from the next cycle. The memory side must tolerate the abandoned request.
- Storage: circular array. head/tail pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is one bit wider so DEPTH is representable.
- full = (count==DEPTH); empty = (count==0). Both are derived from registered count; combinational.
- Push: on posedge with push_en && !full, write entry at tail, set its valid bit, advance tail.
- Push while full is dropped silently. The cache must hold the request, which it does by design.
- Pushed entry is visible to lookup and drain from the next cycle.
- Lookup is combinational:
  - buffer_hit = lookup_en && any valid entry with addr[ADDR_W-1:2]==lookup_addr[ADDR_W-1:2].
  - Priority goes to the youngest entry, nearest tail-1 going backward.
  - lookup_data=0 when there is no hit.
  - An entry being popped this cycle still hits.
- Drain FSM:
  - IDLE: mem_write=0. Go to WRITE when !empty.
  - WRITE: mem_write=1 with mem_addr/mem_data = head entry. Outputs hold stable until mem_ack.
  - On mem_ack: clear head valid and advance head. Stay in WRITE if count>1 (back-to-back, no bubble), else go to IDLE.
  - mem_ack outside WRITE is ignored.
- Simultaneous push and pop: count is unchanged, and both pointers advance.
- Push is still rejected in a cycle where full=1 even if a pop occurs.
- Ordering: memory sees writes in push order. There are no read-around-write hazards because lookups forward the youngest data.

Optional Feature:
- Macro: WBUF_COALESCE_EN.
- Enabled:
  - A push whose word address matches a valid entry overwrites that entry's data in place. count and tail are unchanged.
  - This is accepted even when full.
  - The head entry is excluded while mem_write=1 and treated as in flight; such a push appends normally, or is dropped if full.
- Disabled: every accepted push appends a new entry; duplicate addresses may coexist.

Decomposition:
- Shared package/header (sys_defs.vh): `MEM_ADDR_SIZE, `WORD_SIZE_BIT, `WBUF_DEPTH, and drain FSM state encodings WB_IDLE and WB_WRITE.
- Natural sub-module: wbuf_cam_match.
  - Inputs: valid vector, address array, probe address, head/tail pointers.
  - Outputs: hit flag plus youngest-match index.
  - Reused for lookup, and for the coalesce probe when enabled.

Test Plan:
- Reset, then push 0x100/0xAAAA0001 and 0x104/0xAAAA0002, mem_ack held 0 -> count=2, mem_write=1, mem_addr=0x100 stable. Ack twice -> memory sees 0x100 then 0x104 in consecutive cycles; empty=1 afterwards.
- Push 4 entries with mem_ack=0 -> full=1. 5th push 0x200 is dropped and count stays 4. One ack plus a push the next cycle -> 0x200 accepted at the wrapped tail.
- Push 0x40/0x11 then 0x40/0x22 (coalesce disabled), lookup 0x40 -> buffer_hit=1, lookup_data=0x22. Lookup 0x44 -> buffer_hit=0, lookup_data=0.
- Count=2 with push and ack in the same cycle -> count stays 2 and the FIFO order is preserved. Push at count=4 with a same-cycle ack -> push rejected.
- Assert reset while mem_write=1 with count=3 -> next cycle count=0, empty=1, mem_write=0; subsequent pushes behave normally.
- WBUF_COALESCE_EN: full buffer, push matching non-head address 0x48 data 0x33 -> accepted, count stays 4. Draining delivers 0x33 for 0x48.
